// File: rtl/vga_pkg.sv
// Shared VGA timing types, resolution presets, test-bar colours and width helpers.
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
    };

    localparam vga_timing_t VGA_800x600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    // {r,g,b} per bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    // One spare bit so a counter can hold its own total without wrapping.
    function automatic int unsigned cnt_w(input int unsigned total);
        return $clog2(total) + 1;
    endfunction

    function automatic int unsigned coord_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with synchronous clear; DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_i};
        assign q_o = d_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                stage_q <= '{default: '0};
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with latency-matched pixel fetch and blanked RGB.
// Build option VGA_TEST_PATTERN_EN adds i_test_mode, which replaces RGB with 8 colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640x480_60.h_active,
    parameter int unsigned H_FP     = VGA_640x480_60.h_fp,
    parameter int unsigned H_SYNC   = VGA_640x480_60.h_sync,
    parameter int unsigned H_BP     = VGA_640x480_60.h_bp,
    parameter int unsigned V_ACTIVE = VGA_640x480_60.v_active,
    parameter int unsigned V_FP     = VGA_640x480_60.v_fp,
    parameter int unsigned V_SYNC   = VGA_640x480_60.v_sync,
    parameter int unsigned V_BP     = VGA_640x480_60.v_bp,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned PIX_LAT  = 1
) (
    input  logic                           CLK_IN,
    input  logic                           RST_IN,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                           i_test_mode,
`endif
    input  logic [COLOR_W-1:0]             i_red,
    input  logic [COLOR_W-1:0]             i_green,
    input  logic [COLOR_W-1:0]             i_blue,
    output logic                           o_req,
    output logic [coord_w(H_ACTIVE)-1:0]   o_x,
    output logic [coord_w(V_ACTIVE)-1:0]   o_y,
    output logic                           o_hsync,
    output logic                           o_vsync,
    output logic                           o_de,
    output logic [COLOR_W-1:0]             red,
    output logic [COLOR_W-1:0]             green,
    output logic [COLOR_W-1:0]             blue,
    output logic                           o_frame_start,
    output logic                           o_line_start,
    output logic                           CLK_OUT
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = cnt_w(H_TOTAL);
    localparam int unsigned VW      = cnt_w(V_TOTAL);
    localparam int unsigned XW      = coord_w(H_ACTIVE);
    localparam int unsigned YW      = coord_w(V_ACTIVE);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned PW = 5 + XW;
`else
    localparam int unsigned PW = 5;
`endif

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    logic raw_act, raw_hs, raw_vs, raw_fs, raw_ls;

    assign raw_act = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign raw_hs  = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    assign raw_vs  = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    assign raw_fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign raw_ls  = (h_cnt_q == '0) && (v_cnt_q < V_ACT_END);

    assign o_req   = raw_act && !RST_IN;
    assign o_x     = h_cnt_q[XW-1:0];
    assign o_y     = v_cnt_q[YW-1:0];
    assign CLK_OUT = CLK_IN;

    // Timing flags wait PIX_LAT clocks so they line up with the source's RGB.
    logic [PW-1:0] pipe_d, pipe_q;
    logic          d_act, d_hs, d_vs, d_fs, d_ls;

`ifdef VGA_TEST_PATTERN_EN
    logic [XW-1:0] d_x;
    assign pipe_d = {h_cnt_q[XW-1:0], raw_act, raw_hs, raw_vs, raw_fs, raw_ls};
    assign d_x    = pipe_q[PW-1:5];
`else
    assign pipe_d = {raw_act, raw_hs, raw_vs, raw_fs, raw_ls};
`endif
    assign {d_act, d_hs, d_vs, d_fs, d_ls} = pipe_q[4:0];

    vga_delay_line #(
        .WIDTH (PW),
        .DEPTH (PIX_LAT)
    ) u_align (
        .clk_i (CLK_IN),
        .rst_i (RST_IN),
        .d_i   (pipe_d),
        .q_o   (pipe_q)
    );

    logic [COLOR_W-1:0] red_d, green_d, blue_d;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    logic [2:0] bar_rgb;
    assign bar_idx = 3'((32'(d_x) * 32'd8) / H_ACTIVE);
    assign bar_rgb = BAR_RGB[bar_idx];

    always_comb begin
        red_d   = i_red;
        green_d = i_green;
        blue_d  = i_blue;
        if (i_test_mode) begin
            red_d   = {COLOR_W{bar_rgb[2]}};
            green_d = {COLOR_W{bar_rgb[1]}};
            blue_d  = {COLOR_W{bar_rgb[0]}};
        end
    end
`else
    always_comb begin
        red_d   = i_red;
        green_d = i_green;
        blue_d  = i_blue;
    end
`endif

    logic               de_q, hs_q, vs_q, fs_q, ls_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            de_q    <= 1'b0;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            de_q    <= d_act;
            hs_q    <= d_hs ? H_POL : ~H_POL;
            vs_q    <= d_vs ? V_POL : ~V_POL;
            fs_q    <= d_fs;
            ls_q    <= d_ls;
            red_q   <= d_act ? red_d   : '0;
            green_q <= d_act ? green_d : '0;
            blue_q  <= d_act ? blue_d  : '0;
        end
    end

    assign o_de          = de_q;
    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_frame_start = fs_q;
    assign o_line_start  = ls_q;
    assign red           = red_q;
    assign green         = green_q;
    assign blue          = blue_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates programmable H/V timing, sync pulses with selectable polarity, data-enable, pixel coordinates and frame/line strobes.
- Fetches RGB from an external pixel source with configurable latency; outputs blanked RGB aligned with syncs.
- Sits between the game/board renderer (pixel source) and the DAC/VGA pins. CLK_IN is the pixel clock (25 MHz for 640x480@60).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, clocks
- H_SYNC, 96, hsync width, clocks
- H_BP, 48, horizontal back porch, clocks
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync width, lines
- V_BP, 33, vertical back porch, lines
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)
- COLOR_W, 8, bits per colour channel
- PIX_LAT, 1, pixel-source latency in clocks, from o_req to valid i_red/i_green/i_blue (0..15)

Ports:
- CLK_IN  in  1  pixel clock; all logic on its rising edge
- RST_IN  in  1  synchronous, active-high reset
- i_red  in  COLOR_W  pixel-source red, valid PIX_LAT clocks after o_req
- i_green  in  COLOR_W  pixel-source green
- i_blue  in  COLOR_W  pixel-source blue
- o_req  out  1  current counter position is inside the active area
- o_x  out  clog2(H_ACTIVE)  active column being requested
- o_y  out  clog2(V_ACTIVE)  active row being requested
- o_hsync  out  1  horizontal sync, pipeline-aligned
- o_vsync  out  1  vertical sync, pipeline-aligned
- o_de  out  1  data enable, pipeline-aligned
- red  out  COLOR_W  output red, zero when o_de=0
- green  out  COLOR_W  output green
- blue  out  COLOR_W  output blue
- o_frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame
- o_line_start  out  1  one-clock pulse aligned with the first active pixel of each active line
- CLK_OUT  out  1  CLK_IN forwarded to the DAC

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order per line: active, FP, sync, BP. Frame order per frame is the same, in lines.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments only when h_cnt = H_TOTAL-1; it counts 0..V_TOTAL-1 and wraps to 0 on the same edge that h_cnt wraps at the last line.
- Raw signals (combinational from the counters):
  - act = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Request outputs: o_req = act && !RST_IN. o_x = h_cnt and o_y = v_cnt, truncated; they are don't-care when o_req=0.
- Alignment pipeline: act, hs, vs, fs (h=0,v=0) and ls (h=0,v<V_ACTIVE) pass through a PIX_LAT-stage delay line, then one output register.
  - All timing outputs and RGB appear PIX_LAT+1 clocks after the counter state.
- Output register: red/green/blue = i_* when delayed act=1, else 0. o_hsync = delayed hs ? H_POL : ~H_POL; o_vsync likewise with V_POL.
- Reset (RST_IN=1 at an edge):
  - h_cnt=v_cnt=0; delay lines cleared.
  - Outputs: o_de=0, RGB=0, strobes=0, o_hsync=~H_POL, o_vsync=~V_POL.
  - Reset mid-frame aborts the frame immediately.
  - On the first clock after release, the counters are at (0,0) and o_req=1; o_frame_start pulses PIX_LAT+1 clocks later.
- Widths: counter width = clog2(total)+1 with no overflow; comparisons are unsigned.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined, the block adds port i_test_mode (in, 1).
  - When i_test_mode=1, RGB during active is 8 equal vertical colour bars selected by bar = (delayed x*8)/H_ACTIVE.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
  - In this mode i_red/i_green/i_blue are ignored; o_req still toggles normally.
- When not defined, the port is absent and RGB always comes from the inputs.

Decomposition:
- Package vga_pkg holds:
  - a timing struct typedef (active/fp/sync/bp for each axis);
  - localparam presets VGA_640x480_60 and VGA_800x600_60;
  - the bar colour constant array;
  - a clog2-based width helper.
- One sub-module, vga_delay_line: parametrised WIDTH x DEPTH shift register with synchronous reset; DEPTH=0 is a pass-through. It is used for the alignment pipeline.

Test Plan:
Bench parameters are H 4/1/2/1 (H_TOTAL=8) and V 3/1/1/1 (V_TOTAL=6), PIX_LAT=1, frame = 48 clocks.
- Reset then release: o_req=1 with (x,y)=(0,0) on the first clock; o_frame_start and o_de rise 2 clocks later; o_hsync low for 2 of every 8 clocks, starting 7 clocks after release.
- Full-frame count: exactly 12 o_de cycles, 3 o_line_start pulses and 1 o_frame_start per 48 clocks; o_vsync low for 8 consecutive clocks per frame.
- Pixel echo: source returns {x,y} encoded into red/green one clock after o_req; output shows the matching value exactly when o_de=1, and 0 in blanking even if inputs are 0xFF.
- Polarity: H_POL=1, V_POL=1 inverts both syncs; o_de and RGB timing are unchanged.
- Mid-frame reset at h=5, v=2: all outputs reach their reset values on the next clock; the frame restarts from (0,0) after release.
- With VGA_TEST_PATTERN_EN and i_test_mode=1 at H_ACTIVE=640: pixel x=0 gives FF/FF/FF, x=80 gives FF/FF/00, and x=639 gives 00/00/00.
